// File: rtl/layer_4_conv_scheduler.sv
// Layer-4 featuremap conv scheduler.
// Streams one square input frame into the 3x3 conv bank once per output
// featuremap pass, counts the bank's results into output write addresses,
// flushes the bank between passes and reports completion / error.
module layer_4_conv_scheduler #(
  parameter int IMG_SIZE   = 104,
  parameter int NUM_PASSES = 64,
  parameter int ADDR_W     = 14,
  parameter int SEL_W      = 6,
  parameter int TIMEOUT    = 1024
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              conv_valid_in,
  output logic              conv_clear,
  input  logic              conv_valid_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [SEL_W-1:0]  fmap_sel,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Valid convolution without padding shrinks each dimension by 2.
  localparam int OUT_SIZE = IMG_SIZE - 2;
  localparam int TO_W     = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_PIX_C = ADDR_W'(IMG_SIZE * IMG_SIZE - 1);
  localparam logic [ADDR_W-1:0] EXPECTED_C = ADDR_W'(OUT_SIZE * OUT_SIZE);
  localparam logic [SEL_W-1:0]  LAST_SEL_C = SEL_W'(NUM_PASSES - 1);
  localparam logic [TO_W-1:0]   TO_LAST_C  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   in_cnt_r;
  logic [ADDR_W-1:0]   out_cnt_r;
  logic [TO_W-1:0]     to_cnt_r;
  logic [SEL_W-1:0]    fmap_sel_r;
  logic                error_r;
  logic                conv_clear_r;
  logic                done_r;
  logic                busy_r;
  logic                conv_valid_in_r;

  logic                rd_en_s;
  logic                wr_en_s;
  logic                overflow_s;
  logic                counting_s;

  // Same-cycle strobes: pixel issue follows stall, result write follows the bank's valid_out.
  always_comb begin
    rd_en_s    = 1'b0;
    wr_en_s    = 1'b0;
    overflow_s = 1'b0;
    counting_s = (state_r == ST_STREAM) || (state_r == ST_DRAIN);
    if ((state_r == ST_STREAM) && !stall) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    if (counting_s && conv_valid_out) begin
      if (out_cnt_r == EXPECTED_C) begin
        // A result beyond the expected count is flagged and never written.
        overflow_s = 1'b1;
      end else begin
        wr_en_s = 1'b1;
      end
    end else begin
      wr_en_s    = 1'b0;
      overflow_s = 1'b0;
    end
  end

  // Frame/pass sequencer: state, counters, pass index, sticky error and registered status strobes.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r      <= ST_IDLE;
      in_cnt_r     <= {ADDR_W{1'b0}};
      out_cnt_r    <= {ADDR_W{1'b0}};
      to_cnt_r     <= {TO_W{1'b0}};
      fmap_sel_r   <= {SEL_W{1'b0}};
      error_r      <= 1'b0;
      conv_clear_r <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      conv_clear_r <= 1'b0;
      done_r       <= 1'b0;
      if (wr_en_s) begin
        out_cnt_r <= out_cnt_r + ADDR_W'(1);
      end
      if (overflow_s) begin
        error_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            error_r      <= 1'b0;
            fmap_sel_r   <= {SEL_W{1'b0}};
            conv_clear_r <= 1'b1;
            busy_r       <= 1'b1;
            state_r      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          in_cnt_r  <= {ADDR_W{1'b0}};
          out_cnt_r <= {ADDR_W{1'b0}};
          to_cnt_r  <= {TO_W{1'b0}};
          state_r   <= ST_STREAM;
        end
        ST_STREAM: begin
          if (!stall) begin
            in_cnt_r <= in_cnt_r + ADDR_W'(1);
            if (in_cnt_r == LAST_PIX_C) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_cnt_r == EXPECTED_C) begin
            state_r <= ST_NEXT;
          end else if (conv_valid_out) begin
            to_cnt_r <= {TO_W{1'b0}};
          end else if (to_cnt_r == TO_LAST_C) begin
            // Bank went silent too long: abort every remaining pass.
            error_r <= 1'b1;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end
        ST_NEXT: begin
          if (fmap_sel_r == LAST_SEL_C) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            fmap_sel_r   <= fmap_sel_r + SEL_W'(1);
            conv_clear_r <= 1'b1;
            state_r      <= ST_CLEAR;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Bank valid_in is the read strobe one cycle later, matching the buffer's read latency.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      conv_valid_in_r <= 1'b0;
    end else if (conv_clear_r) begin
      conv_valid_in_r <= 1'b0;
    end else begin
      conv_valid_in_r <= rd_en_s;
    end
  end

  assign rd_en         = rd_en_s;
  assign rd_addr       = in_cnt_r;
  assign conv_valid_in = conv_valid_in_r;
  assign conv_clear    = conv_clear_r;
  assign wr_en         = wr_en_s;
  assign wr_addr       = out_cnt_r;
  assign fmap_sel      = fmap_sel_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;

endmodule

// File: tb/tb_layer_4_conv_scheduler.sv
// Scoreboard bench for layer_4_conv_scheduler with a small frame (4x4, 2 passes).
// Expected read/write address streams are pushed per run; a negedge monitor
// pops and compares whenever the DUT strobes rd_en / wr_en.
module tb_layer_4_conv_scheduler;

  localparam int IMG  = 4;
  localparam int NP   = 2;
  localparam int AW   = 5;
  localparam int SW   = 1;
  localparam int TO   = 8;
  localparam int NPIX = IMG * IMG;
  localparam int EXPR = (IMG - 2) * (IMG - 2);

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          conv_valid_out = 1'b0;
  logic          rd_en, conv_valid_in, conv_clear, wr_en, busy, done, error;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [SW-1:0] fmap_sel;

  layer_4_conv_scheduler #(
    .IMG_SIZE(IMG), .NUM_PASSES(NP), .ADDR_W(AW), .SEL_W(SW), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .stall(stall),
    .rd_en(rd_en), .rd_addr(rd_addr), .conv_valid_in(conv_valid_in),
    .conv_clear(conv_clear), .conv_valid_out(conv_valid_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .fmap_sel(fmap_sel),
    .busy(busy), .done(done), .error(error)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int exp_rd[$];
  int exp_wr[$];
  int cyc = 0;
  int done_cnt = 0, clear_cnt = 0, pass_rd = 0;
  int dstall_cnt = 0, dstall_total = 0;
  int last_vo_cyc = 0, done_cyc = 0;
  int bank_mode = 0;     // 0 normal, 1 only three results, 2 one extra result
  bit rand_stall = 1'b0, dir_stall = 1'b0;
  bit sched[8];
  int pix = 0, qual = 0;
  logic prev_rd = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Input driver: bank results and stall change just after the rising edge.
  initial forever begin
    @(posedge Clk);
    #1;
    cyc++;
    conv_valid_out = sched[cyc % 8];
    sched[cyc % 8] = 1'b0;
    if (conv_clear) dstall_cnt = 0;
    if (dir_stall && pass_rd == 2 && dstall_cnt < 2) begin
      stall = 1'b1;
      dstall_cnt++;
      dstall_total++;
    end else if (rand_stall) begin
      stall = ($urandom_range(0, 3) == 0);
    end else begin
      stall = 1'b0;
    end
  end

  // Monitor and behavioural conv bank, evaluated on the falling edge.
  initial forever begin
    int e;
    @(negedge Clk);
    if (!Rst) begin
      prev_rd = 1'b0; pix = 0; qual = 0; pass_rd = 0;
      for (int i = 0; i < 8; i++) sched[i] = 1'b0;
      continue;
    end
    check("conv_valid_in", conv_valid_in, prev_rd);
    prev_rd = rd_en;
    if (conv_clear) begin
      clear_cnt++; pix = 0; qual = 0; pass_rd = 0;
    end
    if (dir_stall && stall) begin
      check("stall_rd_en", rd_en, 0);
      check("stall_rd_addr", rd_addr, 2);
    end
    if (rd_en) begin
      if (exp_rd.size() == 0) check("rd_unexpected", int'(rd_addr), -1);
      else begin
        e = exp_rd.pop_front();
        check("rd_addr", rd_addr, e % 1024);
        check("rd_fmap", fmap_sel, e / 1024);
      end
      pass_rd++;
    end
    if (wr_en) begin
      if (exp_wr.size() == 0) check("wr_unexpected", int'(wr_addr), -1);
      else begin
        e = exp_wr.pop_front();
        check("wr_addr", wr_addr, e % 1024);
        check("wr_fmap", fmap_sel, e / 1024);
      end
    end
    if (conv_valid_out) last_vo_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_at_done", busy, 0);
    end
    // Bank: a result appears 3 cycles after each pixel completing a 3x3 window.
    if (conv_valid_in) begin
      if ((pix / IMG) >= 2 && (pix % IMG) >= 2) begin
        if (!(bank_mode == 1 && qual >= 3)) sched[(cyc + 3) % 8] = 1'b1;
        qual++;
        if (bank_mode == 2 && qual == EXPR) sched[(cyc + 4) % 8] = 1'b1;
      end
      pix++;
    end
  end

  task automatic push_expect(input int passes, input int nwr);
    exp_rd.delete();
    exp_wr.delete();
    for (int p = 0; p < passes; p++) begin
      for (int a = 0; a < NPIX; a++) exp_rd.push_back(p * 1024 + a);
      for (int w = 0; w < nwr; w++) exp_wr.push_back(p * 1024 + w);
    end
  endtask

  task automatic pulse_start();
    @(posedge Clk); #1; start = 1'b1;
    @(posedge Clk); #1; start = 1'b0;
  endtask

  task automatic run(input int mode, input bit rs, input bit ds, input bit restart_mid);
    int passes;
    passes = (mode == 1) ? 1 : NP;
    bank_mode = mode; rand_stall = rs; dir_stall = ds;
    dstall_total = 0;
    push_expect(passes, (mode == 1) ? 3 : EXPR);
    done_cnt = 0; clear_cnt = 0;
    pulse_start();
    check("busy_after_start", busy, 1);
    if (restart_mid) begin
      for (int i = 0; i < 200 && exp_rd.size() > passes * NPIX - 5; i++) @(posedge Clk);
      #1; start = 1'b1;
      @(posedge Clk); #1; start = 1'b0;
    end
    for (int i = 0; i < 2000 && done_cnt == 0; i++) @(posedge Clk);
    if (done_cnt == 0) check("done_wait_expired", 0, 1);
    repeat (3) @(posedge Clk);
    #1;
    rand_stall = 1'b0; dir_stall = 1'b0;
    check("reads_left", exp_rd.size(), 0);
    check("writes_left", exp_wr.size(), 0);
    check("done_count", done_cnt, 1);
    check("error", error, (mode != 0) ? 1 : 0);
    check("fmap_sel_end", fmap_sel, (mode == 1) ? 0 : NP - 1);
    check("busy_end", busy, 0);
    check("clear_count", clear_cnt, passes);
    if (mode == 1) check("timeout_gap", done_cyc - last_vo_cyc, TO + 1);
    if (ds) check("dir_stall_cycles", dstall_total, 2 * NP);
  endtask

  initial begin
    #2;
    check("rst_rd_en", rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_conv_clear", conv_clear, 0);
    check("rst_rd_addr", rd_addr, 0);
    @(posedge Clk); #1; Rst = 1'b1;

    run(0, 1'b0, 1'b0, 1'b0);   // plain two-pass frame
    run(0, 1'b0, 1'b1, 1'b0);   // two stalled issue cycles per pass
    run(0, 1'b1, 1'b0, 1'b1);   // random stall, start re-pulsed mid-stream
    run(1, 1'b0, 1'b0, 1'b0);   // bank returns too few results: timeout
    run(2, 1'b1, 1'b0, 1'b0);   // bank returns one result too many

    // Reset asserted in the first pass's drain phase.
    bank_mode = 0;
    push_expect(NP, EXPR);
    done_cnt = 0;
    pulse_start();
    for (int i = 0; i < 200 && exp_rd.size() > (NP - 1) * NPIX; i++) @(posedge Clk);
    #1; Rst = 1'b0;
    #1;
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_conv_valid_in", conv_valid_in, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_fmap_sel", fmap_sel, 0);
    repeat (4) @(posedge Clk);
    check("mid_rst_no_done", done_cnt, 0);
    #1; Rst = 1'b1;
    run(0, 1'b1, 1'b0, 1'b0);   // clean run after reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
